spi_top: RTL and testbench
==========================

SPI_TOP -- requirements
Module: spi_top

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide MASTER_FREQ, 100_000_000, system clock frequency in Hz.
REQ-002 SHALL provide SLAVE_FREQ, 1_800_000, target SCLK frequency in Hz.
REQ-003 SHALL provide SPI_MODE, 1, SPI mode 0-3 as {CPOL,CPHA}; mode 1 = CPOL 0, CPHA 1.
REQ-004 SHALL provide SPI_TRF_BIT, 8, word width N in bits.
Ports (name, direction, width, meaning):
REQ-005 SHALL have clk, input, 1, system clock.
REQ-006 SHALL have rst, input, 1, reset; one clock, asynchronous, active-low (0 = reset).
REQ-007 SHALL have req, input, 2, transfer request: 0 idle, 1 master->slave (MOSI), 2 slave->master (MISO), 3 full duplex.
REQ-008 SHALL have wait_duration, input, 8, inter-word gap in clk cycles with CS deasserted.
REQ-009 SHALL have din_master, input, N, word the master transmits.
REQ-010 SHALL have din_slave, input, N, word the slave transmits.
REQ-011 SHALL have dout_master, output, N, word received by the master.
REQ-012 SHALL have dout_slave, output, N, word received by the slave.
REQ-013 SHALL have done_tx, output, 1, one-clk pulse when the master finishes sending a word.
REQ-014 SHALL have done_rx, output, 1, one-clk pulse when the master finishes receiving a word.

Function
REQ-015 SHALL contain sclk_generator_inst (signal sclk), spi_master_inst (state_tx[1:0], state_rx, sclk, sclk_posedge, sclk_negedge, cs) and spi_slave_inst (state_tx, state_rx, sclk_posedge, sclk_negedge), with these hierarchical names reachable by the bench.
REQ-016 SHALL toggle SCLK every HALF = MASTER_FREQ/(2*SLAVE_FREQ) clk cycles (integer division, minimum 1; 27 at defaults); sclk_posedge/sclk_negedge SHALL be one-clk strobes on the corresponding SCLK edges.
REQ-017 SHALL hold SCLK at its CPOL level while CS (active-low) is high.
REQ-018 SHALL transfer MSB first; in mode 1, launch on the SCLK rising edge and sample on the falling edge; other modes SHALL follow standard CPOL/CPHA.
REQ-019 Master state_tx SHALL have states 0 IDLE, 1 SETUP (CS low, one HALF), 2 TRANSFER (N SCLK cycles), 3 GAP (CS high for wait_duration clk cycles), then return to IDLE.
REQ-020 Master state_rx SHALL be 0 IDLE and 1 RECEIVING; slave state_tx and state_rx SHALL each be 0 IDLE and 1 ACTIVE while CS is low for the respective direction.
REQ-021 In IDLE with req != 0, the master SHALL latch req, din_master and din_slave into shift registers and start a transaction; req = 0 SHALL keep everything idle.
REQ-022 A req change mid-word SHALL take effect only at the next IDLE.
REQ-023 dout_slave (req 1/3) and dout_master (req 2/3) SHALL be live shift registers, shifting left one sampled bit per sampling edge, equal to the sent word after N bits, and held until the next word in that direction.
REQ-024 done_tx SHALL pulse for one clk after the Nth sample when req is 1 or 3; done_rx SHALL pulse likewise when req is 2 or 3; with req 3 both SHALL pulse in the same clk.
REQ-025 Directions not selected by req SHALL leave the corresponding dout unchanged and SHALL drive MISO/MOSI low.
REQ-026 Back-to-back words SHALL be separated by the GAP; wait_duration = 0 SHALL give a GAP of one clk.

Reset
REQ-027 While rst = 0, all state machines SHALL be IDLE; CS high, SCLK at CPOL, dout_master = dout_slave = 0, done_tx = done_rx = 0.
REQ-028 Reset asserted mid-transaction SHALL abort the transaction immediately without a done pulse; after release, the block SHALL resume in IDLE.

Verification
REQ-029 req=1, din_master=0xA5, wait_duration=10 -> after 8 SCLK cycles of 54 clk each, dout_slave=0xA5, one done_tx pulse, done_rx stays 0.
REQ-030 req=2, din_slave=0x3C -> dout_master=0x3C, one done_rx pulse, dout_slave unchanged.
REQ-031 req=3, din_master=0x81, din_slave=0x7E -> dout_slave=0x81, dout_master=0x7E, done_tx and done_rx pulse in the same clk.
REQ-032 Five consecutive random req=1 words -> each dout_slave matches its word, with CS high for wait_duration clk between words.
REQ-033 At every SCLK falling edge, the low k bits of dout_slave SHALL equal the top k bits sent so far (dout_master likewise).
REQ-034 rst=0 during bit 4 -> CS high, SCLK low, outputs 0, no done pulse; after release, the next req=1 word completes correctly.

Source files
------------

// File: rtl/spi_top.sv
// SPI master/slave loopback: SCLK generator, master FSM with inter-word gap, and a slave model,
// supporting all four CPOL/CPHA modes with MSB-first words of SPI_TRF_BIT bits.

module sclk_generator #(
    parameter int HALF = 27,
    parameter bit CPOL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_posedge,
    output logic o_negedge
);
    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] r_cnt;
    logic          sclk;
    logic          r_posedge;
    logic          r_negedge;

    // NOTE: clocked blocks use <= so every register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            sclk      <= CPOL;
            r_posedge <= 1'b0;
            r_negedge <= 1'b0;
        end else begin
            r_posedge <= 1'b0;
            r_negedge <= 1'b0;
            if (!i_en) begin
                r_cnt <= '0;
                sclk  <= CPOL;
            end else if (r_cnt == CW'(HALF - 1)) begin
                r_cnt     <= '0;
                sclk      <= ~sclk;
                r_posedge <= ~sclk;
                r_negedge <= sclk;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_sclk    = sclk;
    assign o_posedge = r_posedge;
    assign o_negedge = r_negedge;
endmodule

module spi_master #(
    parameter int N    = 8,
    parameter int HALF = 27,
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   i_req,
    input  logic [7:0]   i_wait,
    input  logic [N-1:0] i_din_master,
    input  logic [N-1:0] i_din_slave,
    input  logic         sclk,
    input  logic         sclk_posedge,
    input  logic         sclk_negedge,
    input  logic         i_miso,
    output logic         o_sclk_en,
    output logic         cs,
    output logic         o_mosi,
    output logic         o_tx_en,
    output logic         o_rx_en,
    output logic         o_load,
    output logic [N-1:0] o_slave_word,
    output logic [N-1:0] o_dout,
    output logic         o_done_tx,
    output logic         o_done_rx
);
    typedef enum logic [1:0] {
        TX_IDLE     = 2'd0,
        TX_SETUP    = 2'd1,
        TX_TRANSFER = 2'd2,
        TX_GAP      = 2'd3
    } tx_state_t;

    typedef enum logic {
        RX_IDLE      = 1'b0,
        RX_RECEIVING = 1'b1
    } rx_state_t;

    localparam int M1      = (HALF > 2 * N) ? HALF : 2 * N;
    localparam int CNT_MAX = (M1 > 256) ? M1 : 256;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(N + 1);

    tx_state_t     state_tx;
    tx_state_t     w_state_next;
    rx_state_t     state_rx;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_bit_cnt;
    logic [1:0]    r_req;
    logic [7:0]    r_wait;
    logic [N-1:0]  r_sr;
    logic [N-1:0]  r_dout;
    logic [N-1:0]  r_slave_word;
    logic          r_bit;
    logic          r_load;
    logic          r_done_tx;
    logic          r_done_rx;
    logic          w_lead;
    logic          w_trail;
    logic          w_sample;
    logic          w_launch;
    logic          w_edge;
    logic          w_start;
    logic          w_setup_last;
    logic          w_xfer_last;
    logic          w_gap_last;

    assign w_lead       = CPOL ? sclk_negedge : sclk_posedge;
    assign w_trail      = CPOL ? sclk_posedge : sclk_negedge;
    assign w_sample     = CPHA ? w_trail : w_lead;
    assign w_launch     = CPHA ? w_lead : w_trail;
    assign w_edge       = sclk_posedge | sclk_negedge;
    assign w_start      = (state_tx == TX_IDLE) && (i_req != 2'b00);
    assign w_setup_last = (r_cnt == CW'(HALF - 1));
    // Leave TRANSFER only on the 2N-th edge, with SCLK already back at its idle level.
    assign w_xfer_last  = w_edge && (r_cnt == CW'(2 * N - 1)) && (sclk == CPOL);
    assign w_gap_last   = (r_wait <= 8'd1) || (r_cnt == CW'(r_wait - 8'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_tx <= TX_IDLE;
        else      state_tx <= w_state_next;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives w_state_next and no latch is inferred.
        w_state_next = state_tx;
        case (state_tx)
            TX_IDLE:     if (w_start)      w_state_next = TX_SETUP;
            TX_SETUP:    if (w_setup_last) w_state_next = TX_TRANSFER;
            TX_TRANSFER: if (w_xfer_last)  w_state_next = TX_GAP;
            TX_GAP:      if (w_gap_last)   w_state_next = TX_IDLE;
            default:                       w_state_next = TX_IDLE;
        endcase
    end

    assign state_rx = (r_req[1] && ((state_tx == TX_SETUP) || (state_tx == TX_TRANSFER)))
                      ? RX_RECEIVING : RX_IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs           <= 1'b1;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_req        <= 2'b00;
            r_wait       <= 8'd0;
            r_sr         <= '0;
            r_dout       <= '0;
            r_slave_word <= '0;
            r_bit        <= 1'b0;
            r_load       <= 1'b0;
            r_done_tx    <= 1'b0;
            r_done_rx    <= 1'b0;
        end else begin
            r_done_tx <= 1'b0;
            r_done_rx <= 1'b0;
            r_load    <= 1'b0;
            cs        <= (w_state_next == TX_IDLE) || (w_state_next == TX_GAP);

            if (w_state_next != state_tx)     r_cnt <= '0;
            else if (state_tx == TX_TRANSFER) begin
                if (w_edge) r_cnt <= r_cnt + CW'(1);
            end else if (state_tx != TX_IDLE) r_cnt <= r_cnt + CW'(1);

            if (w_start) begin
                r_req        <= i_req;
                r_wait       <= i_wait;
                r_slave_word <= i_din_slave;
                r_load       <= 1'b1;
                r_bit_cnt    <= '0;
                // CPHA=0 must present the MSB before the first edge; CPHA=1 launches it on that edge.
                if (CPHA) begin
                    r_sr  <= i_din_master;
                    r_bit <= 1'b0;
                end else begin
                    r_sr  <= i_din_master << 1;
                    r_bit <= i_din_master[N-1];
                end
            end

            if (state_tx == TX_TRANSFER) begin
                if (w_launch) begin
                    r_bit <= r_sr[N-1];
                    r_sr  <= {r_sr[N-2:0], 1'b0};
                end
                if (w_sample) begin
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                    if (state_rx == RX_RECEIVING) r_dout <= {r_dout[N-2:0], i_miso};
                    if (r_bit_cnt == BW'(N - 1)) begin
                        r_done_tx <= r_req[0];
                        r_done_rx <= r_req[1];
                    end
                end
            end
        end
    end

    assign o_sclk_en    = (state_tx == TX_TRANSFER);
    assign o_mosi       = (!cs && r_req[0]) ? r_bit : 1'b0;
    assign o_tx_en      = r_req[0];
    assign o_rx_en      = r_req[1];
    assign o_load       = r_load;
    assign o_slave_word = r_slave_word;
    assign o_dout       = r_dout;
    assign o_done_tx    = r_done_tx;
    assign o_done_rx    = r_done_rx;
endmodule

module spi_slave #(
    parameter int N    = 8,
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cs,
    input  logic         sclk_posedge,
    input  logic         sclk_negedge,
    input  logic         i_tx_en,
    input  logic         i_rx_en,
    input  logic         i_load,
    input  logic [N-1:0] i_word,
    input  logic         i_mosi,
    output logic         o_miso,
    output logic [N-1:0] o_dout
);
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } slave_state_t;

    slave_state_t state_tx;
    slave_state_t state_rx;
    logic [N-1:0] r_sr;
    logic [N-1:0] r_dout;
    logic         r_bit;
    logic         w_lead;
    logic         w_trail;
    logic         w_sample;
    logic         w_launch;

    assign state_tx = (!cs && i_tx_en) ? S_ACTIVE : S_IDLE;
    assign state_rx = (!cs && i_rx_en) ? S_ACTIVE : S_IDLE;
    assign w_lead   = CPOL ? sclk_negedge : sclk_posedge;
    assign w_trail  = CPOL ? sclk_posedge : sclk_negedge;
    assign w_sample = CPHA ? w_trail : w_lead;
    assign w_launch = CPHA ? w_lead : w_trail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr   <= '0;
            r_dout <= '0;
            r_bit  <= 1'b0;
        end else if (i_load) begin
            if (CPHA) begin
                r_sr  <= i_word;
                r_bit <= 1'b0;
            end else begin
                r_sr  <= i_word << 1;
                r_bit <= i_word[N-1];
            end
        end else if (!cs) begin
            if (w_launch) begin
                r_bit <= r_sr[N-1];
                r_sr  <= {r_sr[N-2:0], 1'b0};
            end
            if (w_sample && (state_rx == S_ACTIVE)) r_dout <= {r_dout[N-2:0], i_mosi};
        end
    end

    assign o_miso = (state_tx == S_ACTIVE) ? r_bit : 1'b0;
    assign o_dout = r_dout;
endmodule

module spi_top #(
    parameter int MASTER_FREQ = 100_000_000,
    parameter int SLAVE_FREQ  = 1_800_000,
    parameter int SPI_MODE    = 1,
    parameter int SPI_TRF_BIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req,
    input  logic [7:0]             wait_duration,
    input  logic [SPI_TRF_BIT-1:0] din_master,
    input  logic [SPI_TRF_BIT-1:0] din_slave,
    output logic [SPI_TRF_BIT-1:0] dout_master,
    output logic [SPI_TRF_BIT-1:0] dout_slave,
    output logic                   done_tx,
    output logic                   done_rx
);
    localparam int HALF_RAW = MASTER_FREQ / (2 * SLAVE_FREQ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam bit CPOL     = bit'((SPI_MODE >> 1) & 1);
    localparam bit CPHA     = bit'(SPI_MODE & 1);

    logic                   w_sclk;
    logic                   w_sclk_pos;
    logic                   w_sclk_neg;
    logic                   w_sclk_en;
    logic                   w_cs;
    logic                   w_mosi;
    logic                   w_miso;
    logic                   w_tx_en;
    logic                   w_rx_en;
    logic                   w_load;
    logic [SPI_TRF_BIT-1:0] w_slave_word;

    sclk_generator #(.HALF(HALF), .CPOL(CPOL)) sclk_generator_inst (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_sclk_en),
        .o_sclk    (w_sclk),
        .o_posedge (w_sclk_pos),
        .o_negedge (w_sclk_neg)
    );

    spi_master #(.N(SPI_TRF_BIT), .HALF(HALF), .CPOL(CPOL), .CPHA(CPHA)) spi_master_inst (
        .clk          (clk),
        .rst          (rst),
        .i_req        (req),
        .i_wait       (wait_duration),
        .i_din_master (din_master),
        .i_din_slave  (din_slave),
        .sclk         (w_sclk),
        .sclk_posedge (w_sclk_pos),
        .sclk_negedge (w_sclk_neg),
        .i_miso       (w_miso),
        .o_sclk_en    (w_sclk_en),
        .cs           (w_cs),
        .o_mosi       (w_mosi),
        .o_tx_en      (w_tx_en),
        .o_rx_en      (w_rx_en),
        .o_load       (w_load),
        .o_slave_word (w_slave_word),
        .o_dout       (dout_master),
        .o_done_tx    (done_tx),
        .o_done_rx    (done_rx)
    );

    spi_slave #(.N(SPI_TRF_BIT), .CPOL(CPOL), .CPHA(CPHA)) spi_slave_inst (
        .clk          (clk),
        .rst          (rst),
        .cs           (w_cs),
        .sclk_posedge (w_sclk_pos),
        .sclk_negedge (w_sclk_neg),
        .i_tx_en      (w_rx_en),
        .i_rx_en      (w_tx_en),
        .i_load       (w_load),
        .i_word       (w_slave_word),
        .i_mosi       (w_mosi),
        .o_miso       (w_miso),
        .o_dout       (dout_slave)
    );
endmodule

// File: tb/tb_spi_top.sv
// Directed bench for spi_top in mode 1: table of single words, a back-to-back burst and a mid-word reset.

module tb_spi_top;
    localparam int N      = 8;
    localparam int PERIOD = 54;

    typedef struct {
        logic [1:0] req;
        logic [7:0] dm;
        logic [7:0] ds;
        logic [7:0] wt;
        logic [7:0] exp_m;
        logic [7:0] exp_s;
        logic       exp_tx;
        logic       exp_rx;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   req = 2'd0;
    logic [7:0]   wait_duration = 8'd0;
    logic [N-1:0] din_master = '0;
    logic [N-1:0] din_slave = '0;
    logic [N-1:0] dout_master;
    logic [N-1:0] dout_slave;
    logic         done_tx;
    logic         done_rx;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[7];
    vec_t post;
    logic [7:0] words[5];

    always #5 clk = ~clk;

    spi_top #(
        .MASTER_FREQ (100_000_000),
        .SLAVE_FREQ  (1_800_000),
        .SPI_MODE    (1),
        .SPI_TRF_BIT (N)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .wait_duration (wait_duration),
        .din_master    (din_master),
        .din_slave     (din_slave),
        .dout_master   (dout_master),
        .dout_slave    (dout_slave),
        .done_tx       (done_tx),
        .done_rx       (done_rx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One word: latch, drop req, then watch every clk until the master is back in IDLE.
    task automatic run_word(input vec_t v, input string tag);
        int   cyc = 0, tx_cnt = 0, rx_cnt = 0, both = 0, rise = 0, fall = 0;
        int   first_rise = 0, period = 0, gap = 0;
        bit   prev_neg = 0, prefix_bad = 0, bad_mosi = 0, bad_miso = 0;
        bit   saw_mrx = 0, saw_srx = 0, gap_cs_bad = 0;
        logic [7:0] mk;
        @(negedge clk);
        req = v.req; din_master = v.dm; din_slave = v.ds; wait_duration = v.wt;
        while (dut.spi_master_inst.state_tx == 2'd0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " start"}, 32'(dut.spi_master_inst.state_tx), 32'd1);
        req = 2'd0;
        cyc = 0;
        while (dut.spi_master_inst.state_tx != 2'd0 && cyc < 3000) begin
            if (prev_neg && fall < N) begin
                fall++;
                mk = 8'((1 << fall) - 1);
                if (v.req[0] && ((dout_slave & mk) != (v.dm >> (N - fall)))) prefix_bad = 1;
                if (v.req[1] && ((dout_master & mk) != (v.ds >> (N - fall)))) prefix_bad = 1;
            end
            prev_neg = dut.spi_slave_inst.sclk_negedge;
            if (dut.spi_master_inst.sclk_posedge) begin
                rise++;
                if (rise == 1) first_rise = cyc;
                if (rise == 2) period = cyc - first_rise;
            end
            if (done_tx) tx_cnt++;
            if (done_rx) rx_cnt++;
            if (done_tx && done_rx) both++;
            if (!v.req[0] && dut.w_mosi) bad_mosi = 1;
            if (!v.req[1] && dut.w_miso) bad_miso = 1;
            if (dut.spi_master_inst.state_rx) saw_mrx = 1;
            if (dut.spi_slave_inst.state_rx) saw_srx = 1;
            if (dut.spi_master_inst.state_tx == 2'd3) begin
                gap++;
                if (!dut.spi_master_inst.cs) gap_cs_bad = 1;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " finished in budget"}, 32'(cyc < 3000), 32'd1);
        check({tag, " dout_slave"}, 32'(dout_slave), 32'(v.exp_s));
        check({tag, " dout_master"}, 32'(dout_master), 32'(v.exp_m));
        check({tag, " done_tx pulses"}, 32'(tx_cnt), 32'(v.exp_tx));
        check({tag, " done_rx pulses"}, 32'(rx_cnt), 32'(v.exp_rx));
        check({tag, " done same clk"}, 32'(both), 32'(v.exp_tx & v.exp_rx));
        check({tag, " sclk rises"}, 32'(rise), 32'(N));
        check({tag, " sclk period"}, 32'(period), 32'(PERIOD));
        check({tag, " shift prefix ok"}, 32'(prefix_bad), 32'd0);
        check({tag, " gap clks"}, 32'(gap), (v.wt == 8'd0) ? 32'd1 : 32'(v.wt));
        check({tag, " cs high in gap"}, 32'(gap_cs_bad), 32'd0);
        check({tag, " mosi low unused"}, 32'(bad_mosi), 32'd0);
        check({tag, " miso low unused"}, 32'(bad_miso), 32'd0);
        check({tag, " master rx active"}, 32'(saw_mrx), 32'(v.req[1]));
        check({tag, " slave rx active"}, 32'(saw_srx), 32'(v.req[0]));
        check({tag, " sclk idle after"}, 32'(dut.sclk_generator_inst.sclk), 32'd0);
    endtask

    initial begin
        int cyc;
        int falls;
        int gap;
        int pulses;
        bit cs_bad;

        vecs[0] = '{2'd1, 8'hA5, 8'h00, 8'd10,  8'h00, 8'hA5, 1'b1, 1'b0};
        vecs[1] = '{2'd2, 8'hFF, 8'h3C, 8'd10,  8'h3C, 8'hA5, 1'b0, 1'b1};
        vecs[2] = '{2'd3, 8'h81, 8'h7E, 8'd10,  8'h7E, 8'h81, 1'b1, 1'b1};
        vecs[3] = '{2'd1, 8'h00, 8'hFF, 8'd0,   8'h7E, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{2'd2, 8'h12, 8'h01, 8'd1,   8'h01, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{2'd3, 8'hFF, 8'h80, 8'd3,   8'h80, 8'hFF, 1'b1, 1'b1};
        vecs[6] = '{2'd3, 8'h5A, 8'hC3, 8'd255, 8'hC3, 8'h5A, 1'b1, 1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst cs", 32'(dut.spi_master_inst.cs), 32'd1);
        check("rst sclk", 32'(dut.sclk_generator_inst.sclk), 32'd0);
        check("rst dout_master", 32'(dout_master), 32'd0);
        check("rst dout_slave", 32'(dout_slave), 32'd0);
        check("rst done", 32'({done_tx, done_rx}), 32'd0);
        check("rst state_tx", 32'(dut.spi_master_inst.state_tx), 32'd0);
        rst = 1'b1;

        // req = 0 keeps the block idle.
        repeat (20) @(negedge clk);
        check("idle req0 state", 32'(dut.spi_master_inst.state_tx), 32'd0);
        check("idle req0 cs", 32'(dut.spi_master_inst.cs), 32'd1);

        for (int i = 0; i < 7; i++) run_word(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back req=1 words with a 5-clk gap; req is held so each IDLE relatches.
        for (int i = 0; i < 5; i++) words[i] = 8'($urandom_range(0, 255));
        @(negedge clk);
        wait_duration = 8'd5; din_master = words[0]; req = 2'd1;
        for (int i = 0; i < 5; i++) begin
            cyc = 0;
            while (dut.spi_master_inst.state_tx != 2'd1 && cyc < 1000) begin
                @(negedge clk);
                cyc++;
            end
            check($sformatf("b2b%0d latch", i), 32'(dut.spi_master_inst.state_tx), 32'd1);
            if (i < 4) din_master = words[i+1];
            else       req = 2'd0;
            cyc = 0;
            while (dut.spi_master_inst.state_tx != 2'd3 && cyc < 2000) begin
                @(negedge clk);
                cyc++;
            end
            check($sformatf("b2b%0d done_tx", i), 32'(done_tx), 32'd1);
            check($sformatf("b2b%0d dout_slave", i), 32'(dout_slave), 32'(words[i]));
            gap = 0; cs_bad = 0; cyc = 0;
            while (dut.spi_master_inst.state_tx == 2'd3 && cyc < 1000) begin
                gap++;
                if (!dut.spi_master_inst.cs) cs_bad = 1;
                @(negedge clk);
                cyc++;
            end
            check($sformatf("b2b%0d gap clks", i), 32'(gap), 32'd5);
            check($sformatf("b2b%0d cs high in gap", i), 32'(cs_bad), 32'd0);
        end

        // Reset during bit 4 of a req=1 word aborts it with no done pulse.
        @(negedge clk);
        req = 2'd1; din_master = 8'hC3; wait_duration = 8'd4;
        cyc = 0;
        while (dut.spi_master_inst.state_tx == 2'd0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        req = 2'd0;
        falls = 0; cyc = 0;
        while (falls < 3 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (dut.spi_slave_inst.sclk_negedge) falls++;
        end
        check("abort reached bit 4", 32'(falls), 32'd3);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort cs", 32'(dut.spi_master_inst.cs), 32'd1);
        check("abort sclk", 32'(dut.sclk_generator_inst.sclk), 32'd0);
        check("abort dout_slave", 32'(dout_slave), 32'd0);
        check("abort dout_master", 32'(dout_master), 32'd0);
        check("abort state_tx", 32'(dut.spi_master_inst.state_tx), 32'd0);
        check("abort state_rx", 32'({dut.spi_master_inst.state_rx, dut.spi_slave_inst.state_rx,
                                     dut.spi_slave_inst.state_tx}), 32'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done_tx || done_rx) pulses++;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_tx || done_rx) pulses++;
        end
        check("abort no done pulse", 32'(pulses), 32'd0);

        post = '{2'd1, 8'h69, 8'h00, 8'd2, 8'h00, 8'h69, 1'b1, 1'b0};
        run_word(post, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
